mem_port_arbiter: RTL and testbench

// - Shares the single memory port between the fetch (IF) requester and the EXE load/store unit (LSU).
// - Sequences one outstanding transaction at a time with a req/gnt/rvalid handshake.
// - Routes each response to the requester that issued it. Generates byte enables and lane-aligned store data.
// - Sits between fetch/EXE and the memory interface. LSU has priority; a starvation guard protects IF.

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/mem_lane_align.sv | 53 +++++
 rtl/mem_port_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared types and constants for the memory port arbiter slice.
//   arb_state_t : arbiter FSM state (idle / waiting for the memory response)
//   arb_owner_t : which requester owns the outstanding transaction
//   SIZE_*      : one-hot LSU access size encodings (byte / half / word)
// ----------------------------------------------------------------------------
package riscv_pkg;

    typedef enum logic {
        ARB_IDLE     = 1'b0,
        ARB_WAIT_RSP = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_t;

    localparam logic [2:0] SIZE_B = 3'b001;
    localparam logic [2:0] SIZE_H = 3'b010;
    localparam logic [2:0] SIZE_W = 3'b100;

endpackage

// File: rtl/mem_lane_align.sv
// ----------------------------------------------------------------------------
// mem_lane_align
// Combinational store lane alignment: turns an LSU access size and byte
// offset into memory byte enables and replicates right-justified store data
// onto every lane so the enabled bytes carry the right value.
// Ports:
//   size          in   3         one-hot access size (SIZE_B/SIZE_H/SIZE_W)
//   offset        in   2         byte offset within the word (adr[1:0])
//   wdata         in   XLEN      right-justified store data
//   be            out  XLEN/8    byte enables
//   wdata_aligned out  XLEN      lane-replicated store data
// ----------------------------------------------------------------------------
module mem_lane_align
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        size,
    input  logic [1:0]        offset,
    input  logic [XLEN-1:0]   wdata,
    output logic [XLEN/8-1:0] be,
    output logic [XLEN-1:0]   wdata_aligned
);

    localparam int BE_W = XLEN / 8;

    // Replication means the data is already on whichever lane the enables
    // select, so no data shifter is needed. Misaligned halves are trapped
    // upstream, so the shifted half mask never spills past the word.
    always_comb begin
        be            = '0;
        wdata_aligned = '0;
        case (size)
            SIZE_B: begin
                be            = BE_W'(1) << offset;
                wdata_aligned = {(XLEN/8){wdata[7:0]}};
            end
            SIZE_H: begin
                be            = BE_W'(3) << offset;
                wdata_aligned = {(XLEN/16){wdata[15:0]}};
            end
            SIZE_W: begin
                be            = '1;
                wdata_aligned = wdata;
            end
            default: begin
                be            = '0;
                wdata_aligned = '0;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory port between instruction fetch (IF) and the load/store
// unit (LSU). One transaction is outstanding at a time. LSU has priority,
// but after STARVE_MAX back-to-back LSU grants with IF waiting, IF wins.
// Responses are routed back to the owner; a WAIT_RSP timeout produces an
// error response, and a flushed fetch response is silently dropped.
// Ports:
//   clk, reset_n                      clock, synchronous active-low reset
//   if_req_i/if_adr_i                 fetch read request
//   if_gnt_o/if_rvalid_o/if_rdata_o/if_err_o      fetch handshake/response
//   lsu_req_i/lsu_adr_i/lsu_we_i/lsu_wdata_i/lsu_size_i   LSU request
//   lsu_gnt_o/lsu_rvalid_o/lsu_rdata_o/lsu_err_o  LSU handshake/response
//   flush_i                           pipeline flush
//   mem_req_o/mem_adr_o/mem_we_o/mem_be_o/mem_wdata_o    memory request
//   mem_gnt_i/mem_rvalid_i/mem_rdata_i                    memory handshake
//   busy_o                            transaction outstanding
// ----------------------------------------------------------------------------
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int STARVE_MAX  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req_i,
    input  logic [XLEN-1:0]   if_adr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [XLEN-1:0]   if_rdata_o,
    output logic              if_err_o,
    input  logic              lsu_req_i,
    input  logic [XLEN-1:0]   lsu_adr_i,
    input  logic              lsu_we_i,
    input  logic [XLEN-1:0]   lsu_wdata_i,
    input  logic [2:0]        lsu_size_i,
    output logic              lsu_gnt_o,
    output logic              lsu_rvalid_o,
    output logic [XLEN-1:0]   lsu_rdata_o,
    output logic              lsu_err_o,
    input  logic              flush_i,
    output logic              mem_req_o,
    output logic [XLEN-1:0]   mem_adr_o,
    output logic              mem_we_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i,
    output logic              busy_o
);

    localparam int STREAK_W = $clog2(STARVE_MAX + 1);
    localparam int TIMER_W  = $clog2(TIMEOUT_CYC + 1);

    arb_state_t            state;
    arb_owner_t            owner;
    logic [STREAK_W-1:0]   streak;
    logic [TIMER_W-1:0]    timer;
    logic                  drop;

    logic                  idle;
    logic                  if_cand;
    logic                  force_if;
    logic                  pick_lsu;
    logic                  pick_if;
    logic                  rsp_valid;
    logic                  timeout;
    logic                  rsp_done;
    logic                  if_deliver;
    logic                  lsu_deliver;
    logic [XLEN/8-1:0]     lsu_be;
    logic [XLEN-1:0]       lsu_wdata_al;
    logic                  unused_if_adr_lo;

    mem_lane_align #(.XLEN(XLEN)) u_lane_align (
        .size          (lsu_size_i),
        .offset        (lsu_adr_i[1:0]),
        .wdata         (lsu_wdata_i),
        .be            (lsu_be),
        .wdata_aligned (lsu_wdata_al)
    );

    // Fetch addresses are word aligned; their low bits carry no information.
    assign unused_if_adr_lo = ^if_adr_i[1:0];

    // Arbitration: a flushed fetch is not a candidate. LSU wins unless IF has
    // watched STARVE_MAX consecutive LSU grants and is still asking.
    assign idle     = (state == ARB_IDLE);
    assign if_cand  = if_req_i & ~flush_i;
    assign force_if = if_cand & (streak == STREAK_W'(STARVE_MAX));
    assign pick_lsu = lsu_req_i & ~force_if;
    assign pick_if  = if_cand & ~pick_lsu;

    assign if_gnt_o  = idle & pick_if & mem_gnt_i;
    assign lsu_gnt_o = idle & pick_lsu & mem_gnt_i;
    assign busy_o    = ~idle;

    // Memory request is only presented in IDLE and is driven from the winner.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_adr_o   = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (idle && pick_lsu) begin
            mem_req_o   = 1'b1;
            mem_adr_o   = {lsu_adr_i[XLEN-1:2], 2'b00};
            mem_we_o    = lsu_we_i;
            mem_be_o    = lsu_be;
            mem_wdata_o = lsu_wdata_al;
        end else if (idle && pick_if) begin
            mem_req_o   = 1'b1;
            mem_adr_o   = {if_adr_i[XLEN-1:2], 2'b00};
            mem_be_o    = '1;
        end
    end

    // Completion: a real response beats a timeout landing in the same cycle.
    // A flush arriving in the response cycle itself also suppresses a fetch
    // response, hence flush_i is folded in alongside the registered drop.
    assign rsp_valid   = ~idle & mem_rvalid_i;
    assign timeout     = ~idle & ~mem_rvalid_i & (timer == TIMER_W'(TIMEOUT_CYC));
    assign rsp_done    = rsp_valid | timeout;
    assign if_deliver  = rsp_done & (owner == OWN_IF) & ~(drop | flush_i);
    assign lsu_deliver = rsp_done & (owner == OWN_LSU);

    assign if_rvalid_o  = if_deliver;
    assign if_err_o     = if_deliver & timeout;
    assign if_rdata_o   = (if_deliver & rsp_valid) ? mem_rdata_i : '0;
    assign lsu_rvalid_o = lsu_deliver;
    assign lsu_err_o    = lsu_deliver & timeout;
    assign lsu_rdata_o  = (lsu_deliver & rsp_valid) ? mem_rdata_i : '0;

    // Transaction FSM plus the starvation streak, response timer and the
    // fetch-drop flag. The streak only grows while IF is actually waiting.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= ARB_IDLE;
            owner  <= OWN_IF;
            streak <= '0;
            timer  <= '0;
            drop   <= 1'b0;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (lsu_gnt_o) begin
                        owner <= OWN_LSU;
                        timer <= '0;
                        state <= ARB_WAIT_RSP;
                        if (!if_req_i) begin
                            streak <= '0;
                        end else if (streak != STREAK_W'(STARVE_MAX)) begin
                            streak <= streak + 1'b1;
                        end
                    end else if (if_gnt_o) begin
                        owner  <= OWN_IF;
                        timer  <= '0;
                        state  <= ARB_WAIT_RSP;
                        streak <= '0;
                    end else if (!if_req_i) begin
                        streak <= '0;
                    end
                end
                ARB_WAIT_RSP: begin
                    timer <= timer + 1'b1;
                    if (owner == OWN_IF && flush_i) begin
                        drop <= 1'b1;
                    end
                    if (rsp_done) begin
                        state <= ARB_IDLE;
                        drop  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Scoreboard bench: each scenario pushes the response it expects when it
// issues a request and pops/compares when the DUT answers. A small memory
// model answers each accepted request after mem_lat cycles (0 = never).
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;
    import riscv_pkg::*;

    localparam int XLEN   = 32;
    localparam int STARVE = 4;
    localparam int TMO    = 8;

    typedef struct packed {
        logic        lsu;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req_i;
    logic [31:0] if_adr_i;
    logic        if_gnt_o, if_rvalid_o, if_err_o;
    logic [31:0] if_rdata_o;
    logic        lsu_req_i, lsu_we_i;
    logic [31:0] lsu_adr_i, lsu_wdata_i;
    logic [2:0]  lsu_size_i;
    logic        lsu_gnt_o, lsu_rvalid_o, lsu_err_o;
    logic [31:0] lsu_rdata_o;
    logic        flush_i;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_adr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        busy_o;
    logic [140:0] all_out;

    int          checks = 0;
    int          failures = 0;
    int          mem_lat = 0;
    logic [31:0] mem_data = '0;
    rsp_t        sb[$];

    mem_port_arbiter #(.XLEN(XLEN), .STARVE_MAX(STARVE), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req_i(if_req_i), .if_adr_i(if_adr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
        .lsu_req_i(lsu_req_i), .lsu_adr_i(lsu_adr_i), .lsu_we_i(lsu_we_i),
        .lsu_wdata_i(lsu_wdata_i), .lsu_size_i(lsu_size_i), .lsu_gnt_o(lsu_gnt_o),
        .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o), .lsu_err_o(lsu_err_o),
        .flush_i(flush_i),
        .mem_req_o(mem_req_o), .mem_adr_o(mem_adr_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
    );

    assign all_out = {if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
                      lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o, lsu_err_o,
                      mem_req_o, mem_adr_o, mem_we_o, mem_be_o, mem_wdata_o, busy_o};

    always #5 clk = ~clk;

    // Memory model: a request accepted in cycle 0 gets rvalid in cycle mem_lat.
    initial begin : responder
        int          pend;
        logic        hs;
        logic [31:0] data_q;
        pend = 0;
        data_q = '0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        forever begin
            @(negedge clk);
            hs = mem_req_o && mem_gnt_i && reset_n;
            @(posedge clk);
            #1;
            if (hs === 1'b1) begin
                pend   = mem_lat;
                data_q = mem_data;
            end else if (pend > 0) begin
                pend--;
            end
            mem_rvalid_i = (pend == 1);
            mem_rdata_i  = (pend == 1) ? data_q : 32'h0;
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observes a transaction in WAIT_RSP until busy_o drops (bounded),
    // optionally pulsing flush_i in wait cycle flush_at. Reports only.
    task automatic wait_idle(input int max_cyc, input int flush_at,
                             output int n, output int nrsp, output logic saw_gnt,
                             output logic leak, output rsp_t got);
        n = 0; nrsp = 0; saw_gnt = 1'b0; leak = 1'b0; got = '0;
        while (n < max_cyc) begin
            flush_i = (flush_at != 0) && (n + 1 == flush_at);
            @(negedge clk);
            n++;
            if (if_gnt_o || lsu_gnt_o) saw_gnt = 1'b1;
            if ((!if_rvalid_o && if_rdata_o != 0) || (!lsu_rvalid_o && lsu_rdata_o != 0)) leak = 1'b1;
            if (if_rvalid_o) begin nrsp++; got = '{lsu: 1'b0, rdata: if_rdata_o, err: if_err_o}; end
            if (lsu_rvalid_o) begin nrsp++; got = '{lsu: 1'b1, rdata: lsu_rdata_o, err: lsu_err_o}; end
            tick();
            flush_i = 1'b0;
            if (!busy_o) break;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        checks++;
        if (all_out !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got %h required 0", all_out);
        end
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_if_only();
        int n, nrsp; logic sg, lk; rsp_t got, exp;
        mem_lat = 2; mem_data = 32'hDEADBEEF;
        if_req_i = 1'b1; if_adr_i = 32'h100; mem_gnt_i = 1'b1;
        @(negedge clk);
        checks++;
        if ({if_gnt_o, lsu_gnt_o} !== 2'b10) begin
            failures++; $display("[TB] FAIL if_only_gnt: got if=%b lsu=%b required if=1 lsu=0", if_gnt_o, lsu_gnt_o);
        end
        checks++;
        if ({mem_req_o, mem_we_o, mem_be_o, mem_adr_o} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
            failures++; $display("[TB] FAIL if_only_mem: got req=%b we=%b be=%h adr=%h required 1 0 f 00000100", mem_req_o, mem_we_o, mem_be_o, mem_adr_o);
        end
        sb.push_back('{lsu: 1'b0, rdata: 32'hDEADBEEF, err: 1'b0});
        tick();
        if_req_i = 1'b0; mem_gnt_i = 1'b0;
        wait_idle(20, 0, n, nrsp, sg, lk, got);
        checks++;
        if (n !== 2 || lk !== 1'b0) begin
            failures++; $display("[TB] FAIL if_only_busy: got busy cycles=%0d leak=%b required 2 leak=0", n, lk);
        end
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        checks++;
        if (nrsp !== 1 || got !== exp) begin
            failures++; $display("[TB] FAIL if_only_rsp: got n=%0d rsp=%h required 1 rsp=%h", nrsp, got, exp);
        end
    endtask

    task automatic test_both_request();
        int n, nrsp; logic sg, lk; rsp_t got, exp;
        mem_lat = 1; mem_data = 32'h11111111;
        lsu_req_i = 1'b1; lsu_adr_i = 32'h40; lsu_we_i = 1'b0; lsu_size_i = SIZE_W; lsu_wdata_i = '0;
        if_req_i = 1'b1; if_adr_i = 32'h80; mem_gnt_i = 1'b1;
        @(negedge clk);
        checks++;
        if ({lsu_gnt_o, if_gnt_o, mem_adr_o} !== {1'b1, 1'b0, 32'h40}) begin
            failures++; $display("[TB] FAIL both_lsu_first: got lsu=%b if=%b adr=%h required 1 0 00000040", lsu_gnt_o, if_gnt_o, mem_adr_o);
        end
        sb.push_back('{lsu: 1'b1, rdata: 32'h11111111, err: 1'b0});
        tick();
        lsu_req_i = 1'b0;
        wait_idle(20, 0, n, nrsp, sg, lk, got);
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        checks++;
        if (nrsp !== 1 || got !== exp || sg !== 1'b0) begin
            failures++; $display("[TB] FAIL both_lsu_rsp: got n=%0d rsp=%h gnt_in_wait=%b required 1 rsp=%h 0", nrsp, got, sg, exp);
        end
        mem_data = 32'h22222222;
        @(negedge clk);
        checks++;
        if ({if_gnt_o, lsu_gnt_o, mem_adr_o} !== {1'b1, 1'b0, 32'h80}) begin
            failures++; $display("[TB] FAIL both_if_next: got if=%b lsu=%b adr=%h required 1 0 00000080", if_gnt_o, lsu_gnt_o, mem_adr_o);
        end
        sb.push_back('{lsu: 1'b0, rdata: 32'h22222222, err: 1'b0});
        tick();
        if_req_i = 1'b0; mem_gnt_i = 1'b0;
        wait_idle(20, 0, n, nrsp, sg, lk, got);
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        checks++;
        if (nrsp !== 1 || got !== exp) begin
            failures++; $display("[TB] FAIL both_if_rsp: got n=%0d rsp=%h required 1 rsp=%h", nrsp, got, exp);
        end
    endtask

    task automatic test_starvation();
        int n, nrsp; logic sg, lk, exp_lsu; rsp_t got, exp;
        lsu_req_i = 1'b1; lsu_adr_i = 32'h300; lsu_we_i = 1'b0; lsu_size_i = SIZE_W;
        if_req_i = 1'b1; if_adr_i = 32'h400; mem_gnt_i = 1'b1; mem_lat = 1;
        // Four LSU wins, the forced IF win, then LSU again because IF's grant cleared the streak.
        for (int k = 0; k < 6; k++) begin
            mem_data = 32'hA0 + 32'(k);
            exp_lsu = (k != STARVE);
            @(negedge clk);
            checks++;
            if ({lsu_gnt_o, if_gnt_o} !== {exp_lsu, ~exp_lsu}) begin
                failures++; $display("[TB] FAIL starve_gnt%0d: got lsu=%b if=%b required lsu=%b if=%b", k, lsu_gnt_o, if_gnt_o, exp_lsu, ~exp_lsu);
            end
            sb.push_back('{lsu: exp_lsu, rdata: 32'hA0 + 32'(k), err: 1'b0});
            tick();
            wait_idle(20, 0, n, nrsp, sg, lk, got);
            exp = (sb.size() > 0) ? sb.pop_front() : 'x;
            checks++;
            if (nrsp !== 1 || got !== exp || sg !== 1'b0) begin
                failures++; $display("[TB] FAIL starve_rsp%0d: got n=%0d rsp=%h gnt_in_wait=%b required 1 rsp=%h 0", k, nrsp, got, sg, exp);
            end
        end
        lsu_req_i = 1'b0; if_req_i = 1'b0; mem_gnt_i = 1'b0;
        tick();
    endtask

    task automatic test_store_lanes();
        int n, nrsp; logic sg, lk; rsp_t got, exp;
        logic [31:0] t_adr [5];
        logic [2:0]  t_size [5];
        logic [31:0] t_wd [5];
        logic [3:0]  t_be [5];
        logic [31:0] t_al [5];
        t_adr  = '{32'h203, 32'h202, 32'h201, 32'h210, 32'h20C};
        t_size = '{SIZE_B, SIZE_H, SIZE_B, SIZE_H, SIZE_W};
        t_wd   = '{32'h000000AB, 32'h00001234, 32'h1234565A, 32'hFFFFBEEF, 32'hCAFEF00D};
        t_be   = '{4'b1000, 4'b1100, 4'b0010, 4'b0011, 4'b1111};
        t_al   = '{32'hABABABAB, 32'h12341234, 32'h5A5A5A5A, 32'hBEEFBEEF, 32'hCAFEF00D};
        mem_lat = 1; mem_data = 32'h99999999;
        lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_adr_i = t_adr[0]; lsu_size_i = t_size[0]; lsu_wdata_i = t_wd[0];
        mem_gnt_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_req_o, lsu_gnt_o, busy_o} !== 3'b100) begin
            failures++; $display("[TB] FAIL store_stall: got req=%b gnt=%b busy=%b required 1 0 0", mem_req_o, lsu_gnt_o, busy_o);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            lsu_req_i = 1'b1; lsu_adr_i = t_adr[i]; lsu_size_i = t_size[i]; lsu_wdata_i = t_wd[i];
            mem_gnt_i = 1'b1;
            @(negedge clk);
            checks++;
            if ({lsu_gnt_o, mem_req_o, mem_we_o, mem_adr_o, mem_be_o, mem_wdata_o} !==
                {1'b1, 1'b1, 1'b1, {t_adr[i][31:2], 2'b00}, t_be[i], t_al[i]}) begin
                failures++; $display("[TB] FAIL store_lane%0d: got gnt=%b we=%b adr=%h be=%b wdata=%h required 1 1 %h %b %h",
                                     i, lsu_gnt_o, mem_we_o, mem_adr_o, mem_be_o, mem_wdata_o, {t_adr[i][31:2], 2'b00}, t_be[i], t_al[i]);
            end
            sb.push_back('{lsu: 1'b1, rdata: 32'h99999999, err: 1'b0});
            tick();
            lsu_req_i = 1'b0; mem_gnt_i = 1'b0;
            wait_idle(20, 0, n, nrsp, sg, lk, got);
            exp = (sb.size() > 0) ? sb.pop_front() : 'x;
            checks++;
            if (nrsp !== 1 || got !== exp) begin
                failures++; $display("[TB] FAIL store_rsp%0d: got n=%0d rsp=%h required 1 rsp=%h", i, nrsp, got, exp);
            end
        end
        lsu_we_i = 1'b0;
    endtask

    task automatic test_flush_drop();
        int n, nrsp; logic sg, lk; rsp_t got, exp;
        if_req_i = 1'b1; if_adr_i = 32'h500; flush_i = 1'b1; mem_gnt_i = 1'b1; mem_lat = 4; mem_data = 32'h33333333;
        @(negedge clk);
        checks++;
        if ({mem_req_o, if_gnt_o} !== 2'b00) begin
            failures++; $display("[TB] FAIL flush_idle_block: got req=%b gnt=%b required 0 0", mem_req_o, if_gnt_o);
        end
        tick();
        flush_i = 1'b0;
        @(negedge clk);
        checks++;
        if (if_gnt_o !== 1'b1) begin
            failures++; $display("[TB] FAIL flush_gnt: got %b required 1", if_gnt_o);
        end
        tick();
        if_req_i = 1'b0; mem_gnt_i = 1'b0;
        wait_idle(20, 2, n, nrsp, sg, lk, got);
        checks++;
        if (nrsp !== 0 || n !== 4) begin
            failures++; $display("[TB] FAIL flush_drop_wait: got rsp=%0d cycles=%0d required 0 4", nrsp, n);
        end
        if_req_i = 1'b1; if_adr_i = 32'h504; mem_gnt_i = 1'b1; mem_lat = 1; mem_data = 32'h44444444;
        @(negedge clk);
        checks++;
        if (if_gnt_o !== 1'b1) begin
            failures++; $display("[TB] FAIL flush_next_gnt: got %b required 1", if_gnt_o);
        end
        sb.push_back('{lsu: 1'b0, rdata: 32'h44444444, err: 1'b0});
        tick();
        mem_lat = 3;
        wait_idle(20, 0, n, nrsp, sg, lk, got);
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        checks++;
        if (nrsp !== 1 || got !== exp) begin
            failures++; $display("[TB] FAIL flush_next_rsp: got n=%0d rsp=%h required 1 rsp=%h", nrsp, got, exp);
        end
        // IF still requesting: granted now, flushed in its own response cycle.
        @(negedge clk);
        tick();
        if_req_i = 1'b0; mem_gnt_i = 1'b0;
        wait_idle(20, 3, n, nrsp, sg, lk, got);
        checks++;
        if (nrsp !== 0 || n !== 3) begin
            failures++; $display("[TB] FAIL flush_rvalid_cycle: got rsp=%0d cycles=%0d required 0 3", nrsp, n);
        end
        lsu_req_i = 1'b1; lsu_adr_i = 32'h540; lsu_size_i = SIZE_W; mem_gnt_i = 1'b1; mem_lat = 2; mem_data = 32'h66666666;
        @(negedge clk);
        sb.push_back('{lsu: 1'b1, rdata: 32'h66666666, err: 1'b0});
        tick();
        lsu_req_i = 1'b0; mem_gnt_i = 1'b0;
        wait_idle(20, 1, n, nrsp, sg, lk, got);
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        checks++;
        if (nrsp !== 1 || got !== exp) begin
            failures++; $display("[TB] FAIL flush_lsu_kept: got n=%0d rsp=%h required 1 rsp=%h", nrsp, got, exp);
        end
    endtask

    task automatic test_timeout();
        int n, nrsp; logic sg, lk, bad; rsp_t got, exp;
        // Timer reads 0 in the first wait cycle, so TMO is reached in wait cycle TMO+1.
        if_req_i = 1'b1; if_adr_i = 32'h600; mem_gnt_i = 1'b1; mem_lat = 12; mem_data = 32'h12121212;
        @(negedge clk);
        sb.push_back('{lsu: 1'b0, rdata: 32'h0, err: 1'b1});
        tick();
        if_req_i = 1'b0; mem_gnt_i = 1'b0;
        wait_idle(40, 0, n, nrsp, sg, lk, got);
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        checks++;
        if (nrsp !== 1 || got !== exp || n !== TMO + 1) begin
            failures++; $display("[TB] FAIL timeout_err: got n=%0d rsp=%h cycles=%0d required 1 rsp=%h %0d", nrsp, got, n, exp, TMO + 1);
        end
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (if_rvalid_o || lsu_rvalid_o || if_err_o || lsu_err_o || if_rdata_o != 0 || lsu_rdata_o != 0) bad = 1'b1;
            tick();
        end
        checks++;
        if (bad !== 1'b0) begin
            failures++; $display("[TB] FAIL timeout_late_rvalid: got response=%b required 0", bad);
        end
        lsu_req_i = 1'b1; lsu_adr_i = 32'h640; lsu_size_i = SIZE_W; mem_gnt_i = 1'b1; mem_lat = TMO + 1; mem_data = 32'h55555555;
        @(negedge clk);
        sb.push_back('{lsu: 1'b1, rdata: 32'h55555555, err: 1'b0});
        tick();
        lsu_req_i = 1'b0; mem_gnt_i = 1'b0;
        wait_idle(40, 0, n, nrsp, sg, lk, got);
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        checks++;
        if (nrsp !== 1 || got !== exp || n !== TMO + 1) begin
            failures++; $display("[TB] FAIL timeout_rvalid_wins: got n=%0d rsp=%h cycles=%0d required 1 rsp=%h %0d", nrsp, got, n, exp, TMO + 1);
        end
    endtask

    task automatic test_reset_in_wait();
        if_req_i = 1'b1; if_adr_i = 32'h700; mem_gnt_i = 1'b1; mem_lat = 4; mem_data = 32'h77777777;
        @(negedge clk);
        tick();
        if_req_i = 1'b0; mem_gnt_i = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b1) begin
            failures++; $display("[TB] FAIL rst_wait_busy: got %b required 1", busy_o);
        end
        tick();
        reset_n = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (all_out !== '0) begin
            failures++; $display("[TB] FAIL rst_wait_idle: got %h required 0", all_out);
        end
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_rvalid_i !== 1'b1 || all_out !== '0) begin
            failures++; $display("[TB] FAIL rst_stale_rvalid: got mem_rvalid=%b outputs=%h required 1 and 0", mem_rvalid_i, all_out);
        end
        tick();
    endtask

    initial begin
        reset_n = 1'b0; if_req_i = 1'b0; if_adr_i = '0;
        lsu_req_i = 1'b0; lsu_adr_i = '0; lsu_we_i = 1'b0; lsu_wdata_i = '0; lsu_size_i = SIZE_W;
        flush_i = 1'b0; mem_gnt_i = 1'b0;
        test_reset();
        test_if_only();
        test_both_request();
        test_starvation();
        test_store_lanes();
        test_flush_drop();
        test_timeout();
        test_reset_in_wait();
        checks++;
        if (sb.size() != 0) begin
            failures++; $display("[TB] FAIL scoreboard_empty: got %0d entries required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
